// File: rtl/taiga_config.sv
// taiga_config: core-wide configuration constants
package taiga_config;
  localparam int COMMIT_PORTS = 2;
  localparam int LOG2_COMMIT_PORTS = 1;
endpackage

// File: rtl/taiga_types.sv
// taiga_types: shared instruction-id and writeback request types
package taiga_types;
  typedef logic [3:0] id_t;
  typedef struct packed {
    logic valid;
    logic [4:0] rd_addr;
    logic [31:0] rd_data;
    id_t id;
  } wb_request_t;
endpackage

// File: rtl/wb_port_picker.sv
// wb_port_picker: rotating find-first-N writeback selection with duplicate-address mask
//   req       per-unit writeback requests
//   rr_ptr    unit with highest priority this cycle
//   grant     units granted this cycle
//   conflict  units skipped because an earlier grant already writes the same nonzero rd
//   port_used / port_idx  per write port: occupied, and which unit feeds it
//   next_ptr  unit after the last grant, or rr_ptr when nothing is granted
module wb_port_picker
  import taiga_types::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int WRITE_PORTS = 2,
  parameter int LOG2_WRITE_PORTS = 1,
  parameter int PW = 2
) (
  input wb_request_t [NUM_UNITS-1:0] req,
  input logic [PW-1:0] rr_ptr,
  output logic [NUM_UNITS-1:0] grant,
  output logic [NUM_UNITS-1:0] conflict,
  output logic [WRITE_PORTS-1:0] port_used,
  output logic [WRITE_PORTS-1:0][PW-1:0] port_idx,
  output logic [PW-1:0] next_ptr
);
  int cnt;
  logic [PW-1:0] u;
  logic [LOG2_WRITE_PORTS-1:0] pi;
  logic dup;
  always_comb begin
    grant = '0;
    conflict = '0;
    port_used = '0;
    port_idx = '0;
    next_ptr = rr_ptr;
    cnt = 0;
    u = '0;
    pi = '0;
    dup = 1'b0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      u = PW'((int'(rr_ptr) + i) % NUM_UNITS);
      dup = 1'b0;
      for (int j = 0; j < NUM_UNITS; j++)
        dup = dup | (grant[j] && req[j].rd_addr != 5'd0 && req[j].rd_addr == req[u].rd_addr);
      if (req[u].valid && cnt < WRITE_PORTS) begin
        if (dup) conflict[u] = 1'b1;
        else begin
          pi = LOG2_WRITE_PORTS'(cnt);
          grant[u] = 1'b1;
          port_used[pi] = 1'b1;
          port_idx[pi] = u;
          next_ptr = PW'((int'(u) + 1) % NUM_UNITS);
          cnt = cnt + 1;
        end
      end
    end
  end
endmodule

// File: rtl/writeback_commit_arbiter.sv
// writeback_commit_arbiter: grants unit writebacks onto register-file commit ports, one-cycle latency
//   unit_valid/unit_rd_addr/unit_rd_data/unit_id  per-unit completed results
//   unit_ack    combinational grant, forced low during rst
//   rd_addr/rd_data/rd_id  registered commit payload, held on unused ports
//   rd_retired  registered write strobe, low for unused ports and x0 writes
//   WB_ARB_STATS_EN adds saturating stat_grants and stat_conflicts counters
module writeback_commit_arbiter
  import taiga_config::*, taiga_types::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int WRITE_PORTS = COMMIT_PORTS,
  parameter int LOG2_WRITE_PORTS = LOG2_COMMIT_PORTS
) (
  input logic clk,
  input logic rst,
  input logic [NUM_UNITS-1:0] unit_valid,
  input logic [NUM_UNITS-1:0][4:0] unit_rd_addr,
  input logic [NUM_UNITS-1:0][31:0] unit_rd_data,
  input id_t [NUM_UNITS-1:0] unit_id,
  output logic [NUM_UNITS-1:0] unit_ack,
  output logic [WRITE_PORTS-1:0][4:0] rd_addr,
  output logic [WRITE_PORTS-1:0][31:0] rd_data,
  output id_t [WRITE_PORTS-1:0] rd_id,
  output logic [WRITE_PORTS-1:0] rd_retired
`ifdef WB_ARB_STATS_EN
  ,
  output logic [31:0] stat_grants,
  output logic [31:0] stat_conflicts
`endif
);
  localparam int PW = NUM_UNITS > 1 ? $clog2(NUM_UNITS) : 1;
  wb_request_t [NUM_UNITS-1:0] req;
  logic [NUM_UNITS-1:0] grant, conflict;
  logic [WRITE_PORTS-1:0] port_used;
  logic [WRITE_PORTS-1:0][PW-1:0] port_idx;
  logic [PW-1:0] rr_ptr, next_ptr;
  always_comb
    for (int u = 0; u < NUM_UNITS; u++)
      req[u] = {unit_valid[u], unit_rd_addr[u], unit_rd_data[u], unit_id[u]};
  wb_port_picker #(
    .NUM_UNITS(NUM_UNITS),
    .WRITE_PORTS(WRITE_PORTS),
    .LOG2_WRITE_PORTS(LOG2_WRITE_PORTS),
    .PW(PW)
  ) picker (
    .req(req),
    .rr_ptr(rr_ptr),
    .grant(grant),
    .conflict(conflict),
    .port_used(port_used),
    .port_idx(port_idx),
    .next_ptr(next_ptr)
  );
  assign unit_ack = rst ? '0 : grant;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rr_ptr <= '0;
      rd_retired <= '0;
      rd_addr <= '0;
      rd_data <= '0;
      rd_id <= '0;
    end else begin
      rr_ptr <= next_ptr;
      for (int k = 0; k < WRITE_PORTS; k++) begin
        rd_retired[k] <= port_used[k] && req[port_idx[k]].rd_addr != 5'd0;
        if (port_used[k]) begin
          rd_addr[k] <= req[port_idx[k]].rd_addr;
          rd_data[k] <= req[port_idx[k]].rd_data;
          rd_id[k] <= req[port_idx[k]].id;
        end
      end
    end
`ifdef WB_ARB_STATS_EN
  logic [32:0] g_sum, c_sum;
  assign g_sum = {1'b0, stat_grants} + 33'($countones(grant));
  assign c_sum = {1'b0, stat_conflicts} + 33'($countones(conflict));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stat_grants <= '0;
      stat_conflicts <= '0;
    end else begin
      stat_grants <= g_sum[32] ? '1 : g_sum[31:0];
      stat_conflicts <= c_sum[32] ? '1 : c_sum[31:0];
    end
`endif
endmodule

// File: tb/tb_writeback_commit_arbiter.sv
// tb_writeback_commit_arbiter: directed scoreboard bench for writeback_commit_arbiter
module tb_writeback_commit_arbiter;
  import taiga_types::*;
  typedef struct packed {
    logic [4:0] a;
    logic [31:0] d;
    logic [3:0] id;
    logic r;
  } wb_t;
  logic clk, rst;
  logic [3:0] unit_valid, unit_ack;
  logic [3:0][4:0] unit_rd_addr;
  logic [3:0][31:0] unit_rd_data;
  id_t [3:0] unit_id;
  logic [1:0][4:0] rd_addr;
  logic [1:0][31:0] rd_data;
  id_t [1:0] rd_id;
  logic [1:0] rd_retired;
`ifdef WB_ARB_STATS_EN
  logic [31:0] stat_grants, stat_conflicts;
`endif
  int checks = 0, errors = 0, pending = 0;
  wb_t wb_q[$];
  logic [3:0] ack_q[$];
  wb_t e;
  logic [3:0] ea;
  writeback_commit_arbiter #(.NUM_UNITS(4), .WRITE_PORTS(2), .LOG2_WRITE_PORTS(1)) dut (
    .clk(clk),
    .rst(rst),
    .unit_valid(unit_valid),
    .unit_rd_addr(unit_rd_addr),
    .unit_rd_data(unit_rd_data),
    .unit_id(unit_id),
    .unit_ack(unit_ack),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .rd_id(rd_id),
    .rd_retired(rd_retired)
`ifdef WB_ARB_STATS_EN
    ,
    .stat_grants(stat_grants),
    .stat_conflicts(stat_conflicts)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, act, exp);
    end
  endtask
  task automatic drive(input logic [3:0] v, input logic [3:0][4:0] a, input logic [3:0][31:0] d,
                       input logic [3:0][3:0] id, input logic [3:0] exp_ack);
    @(posedge clk);
    #1;
    unit_valid = v;
    unit_rd_addr = a;
    unit_rd_data = d;
    unit_id = id;
    ack_q.push_back(exp_ack);
  endtask
  task automatic exp_wb(input logic [4:0] a, input logic [31:0] d, input logic [3:0] id, input logic r);
    wb_q.push_back({a, d, id, r});
  endtask
  task automatic idle();
    @(posedge clk);
    #1;
    unit_valid = '0;
  endtask
  always @(negedge clk)
    if (rst) pending = 0;
    else begin
      for (int k = 0; k < 2; k++)
        if (k < pending) begin
          if (wb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL p%0d_commit got retired=%0b want no pending commit", k, rd_retired[k]);
          end else begin
            e = wb_q.pop_front();
            chk($sformatf("p%0d_addr", k), 64'(rd_addr[k]), 64'(e.a));
            chk($sformatf("p%0d_data", k), 64'(rd_data[k]), 64'(e.d));
            chk($sformatf("p%0d_id", k), 64'(rd_id[k]), 64'(e.id));
            chk($sformatf("p%0d_retired", k), 64'(rd_retired[k]), 64'(e.r));
          end
        end else chk($sformatf("p%0d_unused_retired", k), 64'(rd_retired[k]), 64'd0);
      if (ack_q.size() > 0) begin
        ea = ack_q.pop_front();
        chk("unit_ack", 64'(unit_ack), 64'(ea));
        pending = $countones(ea);
      end else pending = 0;
    end
  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    unit_valid = '1;
    unit_rd_addr = '0;
    unit_rd_data = '0;
    unit_id = '0;
    #2;
    chk("rst_retired", 64'(rd_retired), 64'd0);
    chk("rst_addr", 64'(rd_addr), 64'd0);
    chk("rst_data", 64'(rd_data), 64'd0);
    chk("rst_id", 64'(rd_id), 64'd0);
    chk("rst_ack", 64'(unit_ack), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    unit_valid = '0;
    drive(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, {4'd4, 4'd3, 4'd2, 4'd1}, 4'b0011);
    exp_wb(5'd1, 32'hD0, 4'd1, 1'b1);
    exp_wb(5'd2, 32'hD1, 4'd2, 1'b1);
    drive(4'b1100, {5'd4, 5'd3, 5'd2, 5'd1}, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, {4'd4, 4'd3, 4'd2, 4'd1}, 4'b1100);
    exp_wb(5'd3, 32'hD2, 4'd3, 1'b1);
    exp_wb(5'd4, 32'hD3, 4'd4, 1'b1);
    idle();
    drive(4'b0011, {5'd0, 5'd0, 5'd5, 5'd5}, {32'h0, 32'h0, 32'hE1, 32'hE0}, {4'd0, 4'd0, 4'd6, 4'd5}, 4'b0001);
    exp_wb(5'd5, 32'hE0, 4'd5, 1'b1);
    drive(4'b0010, {5'd0, 5'd0, 5'd5, 5'd5}, {32'h0, 32'h0, 32'hE1, 32'hE0}, {4'd0, 4'd0, 4'd6, 4'd5}, 4'b0010);
    exp_wb(5'd5, 32'hE1, 4'd6, 1'b1);
    idle();
`ifdef WB_ARB_STATS_EN
    @(negedge clk);
    chk("stat_conflicts", 64'(stat_conflicts), 64'd1);
    chk("stat_grants", 64'(stat_grants), 64'd6);
`endif
    drive(4'b0100, {5'd0, 5'd0, 5'd0, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0, 32'h0}, {4'd0, 4'd7, 4'd0, 4'd0}, 4'b0100);
    exp_wb(5'd0, 32'hDEADBEEF, 4'd7, 1'b0);
    idle();
    drive(4'b1000, {5'd7, 5'd0, 5'd0, 5'd0}, {32'h12345678, 32'h0, 32'h0, 32'h0}, {4'd8, 4'd0, 4'd0, 4'd0}, 4'b1000);
    exp_wb(5'd7, 32'h12345678, 4'd8, 1'b1);
    idle();
    drive(4'b1111, {5'd11, 5'd10, 5'd9, 5'd8}, {32'hF3, 32'hF2, 32'hF1, 32'hF0}, {4'd12, 4'd11, 4'd10, 4'd9}, 4'b0011);
    exp_wb(5'd8, 32'hF0, 4'd9, 1'b1);
    exp_wb(5'd9, 32'hF1, 4'd10, 1'b1);
    drive(4'b1111, {5'd11, 5'd10, 5'd21, 5'd20}, {32'hF3, 32'hF2, 32'hA1, 32'hA0}, {4'd12, 4'd11, 4'd14, 4'd13}, 4'b1100);
    exp_wb(5'd10, 32'hF2, 4'd11, 1'b1);
    exp_wb(5'd11, 32'hF3, 4'd12, 1'b1);
    drive(4'b1111, {5'd23, 5'd22, 5'd21, 5'd20}, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, {4'd2, 4'd1, 4'd14, 4'd13}, 4'b0011);
    exp_wb(5'd20, 32'hA0, 4'd13, 1'b1);
    exp_wb(5'd21, 32'hA1, 4'd14, 1'b1);
    drive(4'b1111, {5'd23, 5'd22, 5'd21, 5'd20}, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, {4'd2, 4'd1, 4'd14, 4'd13}, 4'b1100);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_retired", 64'(rd_retired), 64'd0);
    chk("rst_mid_ack", 64'(unit_ack), 64'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_ack", 64'(unit_ack), 64'd0);
    chk("rst_hold_retired", 64'(rd_retired), 64'd0);
    chk("rst_hold_addr", 64'(rd_addr), 64'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    unit_valid = '0;
    drive(4'b1111, {5'd19, 5'd18, 5'd17, 5'd16}, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, {4'd3, 4'd2, 4'd1, 4'd0}, 4'b0011);
    exp_wb(5'd16, 32'hB0, 4'd0, 1'b1);
    exp_wb(5'd17, 32'hB1, 4'd1, 1'b1);
    drive(4'b1100, {5'd19, 5'd18, 5'd17, 5'd16}, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, {4'd3, 4'd2, 4'd1, 4'd0}, 4'b1100);
    exp_wb(5'd18, 32'hB2, 4'd2, 1'b1);
    exp_wb(5'd19, 32'hB3, 4'd3, 1'b1);
    idle();
    idle();
    idle();
    @(negedge clk);
    #1;
    chk("ack_q_drained", 64'(ack_q.size()), 64'd0);
    chk("wb_q_drained", 64'(wb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/writeback_commit_arbiter.md
WRITEBACK_COMMIT_ARBITER -- requirements
Module: writeback_commit_arbiter

Interface
REQ-001 SHALL have parameter NUM_UNITS, default 4: number of execution units that present writeback requests.
REQ-002 SHALL have parameter WRITE_PORTS, default COMMIT_PORTS: number of register-file write/commit ports driven.
REQ-003 SHALL have parameter LOG2_WRITE_PORTS, default LOG2_COMMIT_PORTS: width of the port index.
REQ-004 SHALL have port clk, input, 1: the single clock; every flop is rising-edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port unit_valid, input, [NUM_UNITS]: the unit holds a completed result.
REQ-007 SHALL have port unit_rd_addr, input, 5 x NUM_UNITS: destination register.
REQ-008 SHALL have port unit_rd_data, input, 32 x NUM_UNITS: result data.
REQ-009 SHALL have port unit_id, input, id_t x NUM_UNITS: instruction id.
REQ-010 SHALL have port unit_ack, output, [NUM_UNITS]: the request is granted this cycle.
REQ-011 SHALL have port rd_addr, output, 5 x WRITE_PORTS: committed destination.
REQ-012 SHALL have port rd_data, output, 32 x WRITE_PORTS: committed data.
REQ-013 SHALL have port rd_id, output, id_t x WRITE_PORTS: committed id.
REQ-014 SHALL have port rd_retired, output, 1 x WRITE_PORTS: the port writes this cycle; feeds the bank-select tables and the banks.

Function
REQ-015 SHALL grant up to WRITE_PORTS valid requests per cycle, assigning the k-th grant in priority order to port k.
REQ-016 SHALL scan priority in rotating order, starting at pointer rr_ptr.
REQ-017 SHALL advance rr_ptr to (last granted unit + 1) mod NUM_UNITS after any grant, and SHALL leave rr_ptr unchanged when there is no grant.
REQ-018 SHALL assert unit_ack combinationally in the grant cycle; a unit holds its valid, addr, data and id stable until acked and deasserts valid (or presents the next result) the cycle after.
REQ-019 SHALL never grant two requests with the same nonzero rd_addr in one cycle; the later one in priority order is skipped, stays unacked and is retried next cycle.
REQ-020 SHALL ack a request with rd_addr = 0 normally, consume its port, register its id, and drive rd_retired low for that port.
REQ-021 SHALL register outputs one cycle after grant (latency 1); rd_retired is high for exactly one cycle per granted nonzero write.
REQ-022 SHALL drive rd_retired = 0 on unused ports; rd_addr, rd_data and rd_id hold their previous values on those ports.
REQ-023 SHALL, when more than WRITE_PORTS requests are valid, leave the excess unacked; starvation is prevented by rotation.

Reset
REQ-024 SHALL, while rst is high, immediately set rd_retired to all 0, rd_addr, rd_data and rd_id to 0, and rr_ptr to 0.
REQ-025 SHALL force unit_ack to 0 while rst is high; a grant whose capture edge coincides with rst assertion is discarded and not retired.

Configuration
REQ-026 SHALL, with WB_ARB_STATS_EN defined, add outputs stat_grants (32b: count of acks) and stat_conflicts (32b: count of REQ-019 deferrals), both saturating and reset to 0.
REQ-027 SHALL, without WB_ARB_STATS_EN, contain no counters and no stat ports.

Structure
REQ-028 SHALL take id_t and the wb_request_t struct (valid, rd_addr, rd_data, id) from taiga_types; COMMIT_PORTS and LOG2_COMMIT_PORTS come from taiga_config.
REQ-029 SHALL implement selection in one sub-module, wb_port_picker: combinational rotating find-first-N with a duplicate-address mask, producing a grant vector and a per-port unit index.

Verification
REQ-030 SHALL verify rotation: NUM_UNITS=4, WRITE_PORTS=2, all four valid with addrs 1,2,3,4, rr_ptr=0 -> cycle 0 acks units 0,1; cycle 1 ports carry addrs 1,2 with retired=11, and units 2,3 are acked.
REQ-031 SHALL verify conflict: units 0 and 1 valid, both addr 5 -> only unit 0 acked; next cycle unit 1 acked and stat_conflicts=1 when stats are built in.
REQ-032 SHALL verify x0: unit 2 valid, addr 0, data 0xDEADBEEF -> acked, and next cycle rd_retired[0]=0 with rd_id equal to the request id.
REQ-033 SHALL verify a single request: unit 3 only, addr 7, data 0x12345678 -> port 0 next cycle carries 7/0x12345678 with retired=1, port 1 retired=0, rr_ptr=0.
REQ-034 SHALL verify reset mid-operation: rst asserted mid-cycle with grants pending -> rd_retired drops to 0 immediately without waiting for clk, no ack during rst, and rr_ptr=0 after release.
REQ-035 SHALL verify fairness: unit 0 continuously valid with all units valid -> every unit is acked at least once within 2 cycles.
